// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag helpers for the pipelined ALU.
package alu_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    ADD            = 3'd0,
    SUB            = 3'd1,
    BITWISE_INVERT = 3'd2,
    REDUCTION      = 3'd3,
    AND            = 3'd4,
    OR             = 3'd5,
    XOR            = 3'd6,
    ACC            = 3'd7
  } opcode_e;

  // Signed overflow from the operand and result sign bits.
  function automatic logic add_overflow(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_overflow(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Producer/consumer handshake bundle of alu_pipe; slave is the ALU side.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  opcode_e          opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, c, zero, carry, overflow, illegal
  );

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, c, zero, carry, overflow, illegal
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath. The ACC opcode is only implemented when the
// ALU_ACC_EN macro is defined; otherwise it is flagged illegal.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  opcode_e          opcode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] c_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             illegal_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;

  assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
  // The extra MSB of the zero-extended difference is the unsigned borrow.
  assign diff_s = {1'b0, a_i} - {1'b0, b_i};

`ifdef ALU_ACC_EN
  logic [WIDTH:0] acc_sum_s;
  assign acc_sum_s = {1'b0, acc_i} + {1'b0, a_i};
`else
  logic unused_acc_s;
  assign unused_acc_s = ^acc_i;
`endif

  always_comb begin
    c_o        = {WIDTH{1'b0}};
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    illegal_o  = 1'b0;
    case (opcode_i)
      ADD: begin
        c_o        = sum_s[WIDTH-1:0];
        carry_o    = sum_s[WIDTH];
        overflow_o = add_overflow(a_i[WIDTH-1], b_i[WIDTH-1], sum_s[WIDTH-1]);
      end
      SUB: begin
        c_o        = diff_s[WIDTH-1:0];
        carry_o    = diff_s[WIDTH];
        overflow_o = sub_overflow(a_i[WIDTH-1], b_i[WIDTH-1], diff_s[WIDTH-1]);
      end
      BITWISE_INVERT: c_o = ~a_i;
      REDUCTION:      c_o = {{(WIDTH-1){1'b0}}, |b_i};
      AND:            c_o = a_i & b_i;
      OR:             c_o = a_i | b_i;
      XOR:            c_o = a_i ^ b_i;
      ACC: begin
`ifdef ALU_ACC_EN
        c_o        = acc_sum_s[WIDTH-1:0];
        carry_o    = acc_sum_s[WIDTH];
        overflow_o = add_overflow(acc_i[WIDTH-1], a_i[WIDTH-1], acc_sum_s[WIDTH-1]);
`else
        illegal_o  = 1'b1;
`endif
      end
      default: c_o = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with full-throughput backpressure.
// Defining ALU_ACC_EN adds the running accumulator used by the ACC opcode.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);

  logic             s1_valid_q, s1_valid_d;
  opcode_e          s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_c_q,     s2_c_d;
  logic             s2_zero_q,  s2_zero_d;
  logic             s2_carry_q, s2_carry_d;
  logic             s2_ovf_q,   s2_ovf_d;
  logic             s2_ill_q,   s2_ill_d;

  logic             s2_load_s, in_ready_s, in_fire_s;
  logic [WIDTH-1:0] acc_s, core_c_s;
  logic             core_carry_s, core_ovf_s, core_ill_s;

  assign s2_load_s  = s1_valid_q && (!s2_valid_q || bus.out_ready);
  assign in_ready_s = !s1_valid_q || s2_load_s;
  assign in_fire_s  = bus.in_valid && in_ready_s;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .opcode_i   (s1_op_q),
    .a_i        (s1_a_q),
    .b_i        (s1_b_q),
    .acc_i      (acc_s),
    .c_o        (core_c_s),
    .carry_o    (core_carry_s),
    .overflow_o (core_ovf_s),
    .illegal_o  (core_ill_s)
  );

`ifdef ALU_ACC_EN
  logic [WIDTH-1:0] acc_q, acc_d;

  // Accumulator advances with the ACC beat as it moves into S2.
  always_comb begin
    if (s2_load_s && (s1_op_q == ACC)) begin
      acc_d = core_c_s;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= {WIDTH{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_s = acc_q;
`else
  assign acc_s = {WIDTH{1'b0}};
`endif

  // Next state of both stages; S2 data holds while drained so outputs stay stable.
  always_comb begin
    s1_op_d = s1_op_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    if (in_fire_s) begin
      s1_valid_d = 1'b1;
      s1_op_d    = bus.opcode;
      s1_a_d     = bus.a;
      s1_b_d     = bus.b;
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    s2_c_d     = s2_c_q;
    s2_zero_d  = s2_zero_q;
    s2_carry_d = s2_carry_q;
    s2_ovf_d   = s2_ovf_q;
    s2_ill_d   = s2_ill_q;
    if (s2_load_s) begin
      s2_valid_d = 1'b1;
      s2_c_d     = core_c_s;
      s2_zero_d  = (core_c_s == {WIDTH{1'b0}});
      s2_carry_d = core_carry_s;
      s2_ovf_d   = core_ovf_s;
      s2_ill_d   = core_ill_s;
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= ADD;
      s1_a_q     <= {WIDTH{1'b0}};
      s1_b_q     <= {WIDTH{1'b0}};
      s2_valid_q <= 1'b0;
      s2_c_q     <= {WIDTH{1'b0}};
      s2_zero_q  <= 1'b0;
      s2_carry_q <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_ill_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_c_q     <= s2_c_d;
      s2_zero_q  <= s2_zero_d;
      s2_carry_q <= s2_carry_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_ill_q   <= s2_ill_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_q;
  assign bus.c         = s2_c_q;
  assign bus.zero      = s2_zero_q;
  assign bus.carry     = s2_carry_q;
  assign bus.overflow  = s2_ovf_q;
  assign bus.illegal   = s2_ill_q;

endmodule
